// File: rtl/fir_sym_pkg.sv
// fir_sym_pkg: shared constants, types and coefficient table for the
// symmetric low-pass FIR (fir_sym_pipe) and its adder tree.
//   WD      sample width (in and out), two's complement
//   N_TAP   filter length (odd, symmetric coefficients)
//   COEF_W  coefficient width, signed Q1.15
//   NP      number of pre-added tap pairs, centre tap included
//   LAT     input-to-output latency in clk cycles
package fir_sym_pkg;

  localparam int WD      = 24;
  localparam int N_TAP   = 15;
  localparam int COEF_W  = 16;
  localparam int NP      = (N_TAP + 1) / 2;
  localparam int TREE_LV = $clog2(NP);
  localparam int LAT     = 4 + TREE_LV;

  // Internal datapath widths: pre-add grows one bit, the multiply adds the
  // coefficient width, and every adder tree level adds one more bit.
  localparam int PRE_W  = WD + 1;
  localparam int PROD_W = PRE_W + COEF_W;
  localparam int ACC_W  = PROD_W + TREE_LV;
  localparam int FRAC_W = COEF_W - 1;

  typedef logic signed [WD-1:0]     sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  // First half of the symmetric impulse response, h[0] .. h[NP-1].
  // The last entry is the centre tap. Full sum over all N_TAP taps is 32768,
  // giving unity DC gain; the small negative side taps make sum(|h|) exceed
  // 32768, so a sign-aligned full-scale input can overflow and must saturate.
  localparam coef_t H [NP] = '{
    -16'sd100, -16'sd300, -16'sd200, 16'sd500,
     16'sd2000, 16'sd4500, 16'sd6500, 16'sd6968
  };

  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(2 ** (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'((2 ** (WD - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-(2 ** (WD - 1)));

  // Round half up, drop the Q1.15 fraction, then clamp to the sample range.
  function automatic sample_t round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + ROUND_BIAS) >>> FRAC_W;
    if (r > SAT_MAX)
      return {1'b0, {(WD-1){1'b1}}};
    else if (r < SAT_MIN)
      return {1'b1, {(WD-1){1'b0}}};
    else
      return r[WD-1:0];
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree: pipelined binary reduction of N_IN signed products.
// One register per tree level, so the sum appears LV cycles after its inputs.
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears every level
//   prod_flat  N_IN products of IN_W bits, product i at bits [i*IN_W +: IN_W]
//   sum_out    registered total, IN_W+LV bits
module fir_adder_tree #(
  parameter int N_IN = 8,
  parameter int IN_W = 41,
  parameter int LV   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*IN_W-1:0]   prod_flat,
  output logic [IN_W+LV-1:0]     sum_out
);

  localparam int OUT_W  = IN_W + LV;
  localparam int LEAVES = 2 ** LV;

  logic signed [OUT_W-1:0] leaf [LEAVES];
  // Heap-ordered tree: node 1 is the root, node i sums nodes 2i and 2i+1;
  // nodes LEAVES/2 .. LEAVES-1 sit directly above the leaves.
  logic signed [OUT_W-1:0] node [1:LEAVES-1];

  // Sign-extend each product to the full output width; unused leaves are zero.
  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      leaf[i] = '0;
      if (i < N_IN)
        leaf[i] = {{LV{prod_flat[i*IN_W+IN_W-1]}}, prod_flat[i*IN_W +: IN_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < LEAVES; i++)
        node[i] <= '0;
    end else begin
      for (int i = LEAVES / 2; i < LEAVES; i++)
        node[i] <= leaf[2*i-LEAVES] + leaf[2*i+1-LEAVES];
      for (int i = 1; i < LEAVES / 2; i++)
        node[i] <= node[2*i] + node[2*i+1];
    end
  end

  assign sum_out = node[1];

endmodule

// File: rtl/fir_sym_pipe.sv
// fir_sym_pipe: streaming symmetric low-pass FIR, one sample in and one out
// per clk, fixed latency LAT, no handshake.
// Stages: delay line -> pre-add of mirrored taps -> multiply -> adder tree
// -> round/saturate output register.
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears all pipeline state
//   sam_in    input sample, taken every rising edge
//   data_out  filtered sample, registered
module fir_sym_pipe
  import fir_sym_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [WD-1:0] sam_in,
  output logic [WD-1:0] data_out
);

  // Tree depth follows from the overall latency budget.
  localparam int TREE_STAGES = LAT - 4;

  sample_t                  dly  [N_TAP];
  logic signed [PRE_W-1:0]  pre  [NP];
  logic signed [PROD_W-1:0] prod [NP];
  logic [NP*PROD_W-1:0]     prod_flat;
  logic [ACC_W-1:0]         acc;

  // Delay line: dly[k] holds x[n-k].
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_TAP; k++)
        dly[k] <= '0;
    end else begin
      dly[0] <= sam_in;
      for (int k = 1; k < N_TAP; k++)
        dly[k] <= dly[k-1];
    end
  end

  // Pre-add mirrored taps, which share a coefficient; the centre tap has no
  // partner and is only sign-extended.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NP; k++)
        pre[k] <= '0;
    end else begin
      for (int k = 0; k < NP - 1; k++)
        pre[k] <= {dly[k][WD-1], dly[k]} + {dly[N_TAP-1-k][WD-1], dly[N_TAP-1-k]};
      pre[NP-1] <= {dly[NP-1][WD-1], dly[NP-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NP; k++)
        prod[k] <= '0;
    end else begin
      for (int k = 0; k < NP; k++)
        prod[k] <= PROD_W'(pre[k]) * PROD_W'(H[k]);
    end
  end

  always_comb begin
    prod_flat = '0;
    for (int k = 0; k < NP; k++)
      prod_flat[k*PROD_W +: PROD_W] = prod[k];
  end

  fir_adder_tree #(
    .N_IN (NP),
    .IN_W (PROD_W),
    .LV   (TREE_STAGES)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .prod_flat (prod_flat),
    .sum_out   (acc)
  );

  always_ff @(posedge clk) begin
    if (rst)
      data_out <= '0;
    else
      data_out <= round_sat(acc);
  end

endmodule

// File: tb/tb_fir_sym_pipe.sv
// tb_fir_sym_pipe: self-checking bench for fir_sym_pipe.
// A behavioural model keeps the sample history since the last reset and
// evaluates y[n] = sum h[k]*x[n-k] directly with 64-bit arithmetic.
module tb_fir_sym_pipe;

  localparam int OUT_DLY = 6;  // edges between sample capture and its output

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] sam_in = '0;
  logic [23:0] data_out;

  int check_count = 0;
  int pass_count  = 0;

  // Full 15-tap impulse response written out independently of the design.
  int hfull [15] = '{-100, -300, -200, 500, 2000, 4500, 6500, 6968,
                     6500, 4500, 2000, 500, -200, -300, -100};

  int hist [$];       // sample captured at each edge, indexed by edge number
  int cyc       = 0;  // number of edges applied so far
  int last_rst  = -1; // most recent edge at which rst was sampled high

  fir_sym_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .sam_in   (sam_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Drive one sample for one edge, record it in the model, settle past the edge.
  task automatic drive_cycle(input logic [23:0] s, input bit r);
    sam_in = s;
    rst    = r;
    @(posedge clk);
    hist.push_back(int'($signed(s)));
    if (r) last_rst = cyc;
    cyc++;
    #1;
  endtask

  // Expected data_out after the most recent edge.
  function automatic logic [23:0] ref_output();
    longint acc = 0;
    int m = cyc - 1 - OUT_DLY;
    for (int k = 0; k < 15; k++) begin
      int j = m - k;
      if (j >= 0 && j > last_rst)
        acc += longint'(hfull[k]) * longint'(hist[j]);
    end
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 64'sd8388607)  return 24'h7FFFFF;
    if (acc < -64'sd8388608) return 24'h800000;
    return acc[23:0];
  endfunction

  function automatic logic [23:0] sine_sample(input int n);
    real v;
    v = 8388607.0 * $sin(2.0 * 3.14159265358979 * real'(n) / 48.0);
    return 24'($rtoi(v));
  endfunction

  task automatic test_reset();
    logic [23:0] exp_v;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(24'h7FFFFF, 1'b1);
      check_count++;
      if (data_out !== 24'h000000)
        $display("[TB] FAIL reset_hold: data_out=%h expected=000000", data_out);
      else pass_count++;
    end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(24'h000000, 1'b0);
      exp_v = ref_output();
      check_count++;
      if (data_out !== 24'h000000 || exp_v !== 24'h000000)
        $display("[TB] FAIL reset_zero_in: data_out=%h model=%h expected=000000", data_out, exp_v);
      else pass_count++;
    end
  endtask

  task automatic test_impulse();
    logic [23:0] exp_v;
    drive_cycle(24'h100000, 1'b0);
    for (int i = 0; i < OUT_DLY - 1; i++) begin
      drive_cycle(24'h000000, 1'b0);
      check_count++;
      if (data_out !== 24'h000000)
        $display("[TB] FAIL impulse_pre: data_out=%h expected=000000", data_out);
      else pass_count++;
    end
    for (int k = 0; k < 15; k++) begin
      drive_cycle(24'h000000, 1'b0);
      exp_v = 24'(hfull[k] * 32);
      check_count++;
      if (data_out !== exp_v)
        $display("[TB] FAIL impulse_tap%0d: data_out=%h expected=%h", k, data_out, exp_v);
      else pass_count++;
    end
    drive_cycle(24'h000000, 1'b0);
    check_count++;
    if (data_out !== 24'h000000)
      $display("[TB] FAIL impulse_tail: data_out=%h expected=000000", data_out);
    else pass_count++;
  endtask

  task automatic test_dc();
    logic [23:0] lvl [2];
    logic [23:0] exp_v;
    lvl[0] = 24'h100000;
    lvl[1] = 24'hF00000;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 22; i++) begin
        drive_cycle(lvl[p], 1'b0);
        exp_v = ref_output();
        check_count++;
        if (data_out !== exp_v)
          $display("[TB] FAIL dc_model: data_out=%h expected=%h", data_out, exp_v);
        else pass_count++;
      end
      check_count++;
      if (data_out !== lvl[p])
        $display("[TB] FAIL dc_settled: data_out=%h expected=%h", data_out, lvl[p]);
      else pass_count++;
    end
  endtask

  task automatic test_saturation();
    logic [23:0] exp_v;
    logic [23:0] pos_v;
    logic [23:0] neg_v;
    logic [23:0] sat_v;
    for (int p = 0; p < 2; p++) begin
      pos_v = (p == 0) ? 24'h7FFFFF : 24'h800000;
      neg_v = (p == 0) ? 24'h800000 : 24'h7FFFFF;
      sat_v = (p == 0) ? 24'h7FFFFF : 24'h800000;
      // Oldest sample first; symmetry makes its tap sign that of hfull[j].
      for (int j = 0; j < 15; j++)
        drive_cycle((hfull[j] > 0) ? pos_v : neg_v, 1'b0);
      for (int i = 0; i < OUT_DLY; i++) begin
        drive_cycle(24'h000000, 1'b0);
        exp_v = ref_output();
        check_count++;
        if (data_out !== exp_v)
          $display("[TB] FAIL sat_model: data_out=%h expected=%h", data_out, exp_v);
        else pass_count++;
      end
      check_count++;
      if (data_out !== sat_v)
        $display("[TB] FAIL sat_clamp: data_out=%h expected=%h", data_out, sat_v);
      else pass_count++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [23:0] exp_v;
    for (int n = 0; n < 30; n++) begin
      drive_cycle(sine_sample(n), 1'b0);
      exp_v = ref_output();
      check_count++;
      if (data_out !== exp_v)
        $display("[TB] FAIL mid_pre: data_out=%h expected=%h", data_out, exp_v);
      else pass_count++;
    end
    drive_cycle(24'($urandom), 1'b1);
    check_count++;
    if (data_out !== 24'h000000)
      $display("[TB] FAIL mid_reset: data_out=%h expected=000000", data_out);
    else pass_count++;
    for (int n = 30; n < 70; n++) begin
      drive_cycle(sine_sample(n), 1'b0);
      exp_v = ref_output();
      check_count++;
      if (data_out !== exp_v)
        $display("[TB] FAIL mid_post: data_out=%h expected=%h", data_out, exp_v);
      else pass_count++;
    end
  endtask

  task automatic test_sine();
    logic [23:0] exp_v;
    for (int n = 0; n < 150; n++) begin
      drive_cycle(sine_sample(n), 1'b0);
      exp_v = ref_output();
      check_count++;
      if (data_out !== exp_v)
        $display("[TB] FAIL sine: n=%0d data_out=%h expected=%h", n, data_out, exp_v);
      else pass_count++;
    end
  endtask

  task automatic test_random();
    logic [23:0] exp_v;
    for (int n = 0; n < 200; n++) begin
      drive_cycle(24'($urandom), 1'b0);
      exp_v = ref_output();
      check_count++;
      if (data_out !== exp_v)
        $display("[TB] FAIL random: n=%0d data_out=%h expected=%h", n, data_out, exp_v);
      else pass_count++;
    end
  endtask

  initial begin
    $display("[TB] starting fir_sym_pipe bench");
    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_reset_midstream();
    test_sine();
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
